vector_wb_collector: RTL and testbench
======================================

# vector_wb_collector

Write-side companion to the vector register file. Accepts a stream of SEW-bit element results, one element per handshake, and assembles them lane by lane into a full VL*SEW vector. Once all VL lanes are collected, it issues a single-cycle write (write, is_v, vd_addr, data) that the register file's write port consumes directly. It sits between the vector execution/load pipeline and the register file.

## Interface
- VL, 8, elements per vector register
- SEW, 32, element width in bits

- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a new collection; sampled only in IDLE
- vd_in  in  5  destination register index, latched on accepted start
- elem_valid  in  1  element producer has data
- elem_data  in  SEW  element value
- elem_ready  out  1  collector accepts an element this cycle
- busy  out  1  high in COLLECT and WRITE
- write  out  1  register-file write strobe, one cycle
- is_v  out  1  vector-write qualifier; equals write
- vd_addr  out  5  latched destination index
- data  out  VL*SEW  assembled vector; lane i at data[i*SEW +: SEW]
- vmask  in  VL  per-lane write enable, latched on accepted start (VMASK_EN only)
- old_data  in  VL*SEW  current contents of vd; drive from a register-file read port addressed by vd_addr (VMASK_EN only)

## Operation
- States: IDLE, COLLECT, WRITE.
- IDLE: elem_ready=0, busy=0. When start=1, latch vd_in into vd_addr, clear lane index idx=0, and go to COLLECT. Without VMASK_EN, clear the data buffer to 0.
- COLLECT: elem_ready=1 and busy=1. On elem_valid&elem_ready, store elem_data into lane idx and increment idx. After the lane VL-1 element is accepted, go to WRITE. Cycles with elem_valid=0 change no state.
- WRITE: write=1, is_v=1, busy=1, elem_ready=0 for exactly one cycle, then return to IDLE.
- start is ignored outside IDLE. vd_in is not re-sampled.
- idx is $clog2(VL) bits wide. It never wraps inside a collection because the transition to WRITE happens at lane VL-1.
- vd_addr=0 is a legal destination with no special casing.
- data holds its last assembled value after WRITE, until the next start.
- Reset in any state returns to IDLE. No write is issued, and partially collected lanes are discarded.
- Reset values: state=IDLE, elem_ready=0, busy=0, write=0, is_v=0, vd_addr=0, data=0, idx=0.

## Timing
- Cycle 0: start=1 in IDLE.
- Cycle 1: elem_ready=1.
- With elem_valid held high from cycle 1, lane i is accepted in cycle 1+i and the last lane in cycle VL.
- Cycle VL+1: write=1.
- Cycle VL+2: IDLE. Earliest next accepted start is cycle VL+2.
- Latency from the last accepted element to write is exactly 1 cycle. Every element-valid bubble adds 1 cycle.
- write, is_v, vd_addr and data are registered, with no combinational path from inputs. data is stable during the write cycle.
- elem_ready depends only on state, not on elem_valid.

## Configuration
- VMASK_EN defined:
  - vmask and old_data ports exist, and vmask is latched on accepted start.
  - When lane idx is accepted: if vmask[idx]=1, store elem_data; otherwise store old_data[idx*SEW +: SEW] (mask-undisturbed).
  - Masked lanes still consume one element handshake, so the stream length is always VL.
  - The data buffer is not cleared on start.
- VMASK_EN undefined: no vmask or old_data ports, and every lane takes elem_data.

## Test plan
- Reset then idle (VL=8, SEW=32): rst=1 for 2 cycles, then low -> write=0, busy=0, elem_ready=0, data=0, vd_addr=0; no write for 20 cycles.
- Continuous stream: start with vd_in=5, elements 0x10..0x17 with valid held high -> write=1 exactly once in cycle 9, vd_addr=5, data lane i=0x10+i, busy low in cycle 10.
- Bubbles and ignored start: same stream with elem_valid low every other cycle, plus start pulsed with vd_in=9 mid-collection -> write in cycle 16, vd_addr=5, lanes correct.
- Reset mid-collection: rst=1 after 4 accepted lanes, then a new start with vd_in=0 and elements 0xA0..0xA7 -> only one write, vd_addr=0, data lanes 0xA0..0xA7, no stale lanes.
- Back-to-back: second start asserted in cycle 9 (ignored) and again in cycle 10 (accepted), vd_in=31 -> two writes, in cycles 9 and 19, second with vd_addr=31.
- VMASK_EN: vmask=8'b0101_0101, old_data lanes=0xFFFF_FFFF, elements 0..7 -> even lanes = i, odd lanes = 0xFFFF_FFFF, 8 handshakes consumed.

Source files
------------

// File: rtl/vector_wb_collector.sv
// ---------------------------------------------------------------------------
// vector_wb_collector
//   Gathers a stream of SEW-bit element results, one per valid/ready
//   handshake, into a VL*SEW vector and issues a single-cycle write to the
//   vector register file once all VL lanes are in.
//
// Optional feature macro: VMASK_EN
//   When defined, per-lane masking is enabled. Masked-off lanes keep the old
//   contents of vd (taken from old_data), but each one still consumes one
//   element handshake.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   start        begin a collection (only honoured in IDLE)
//   vd_in        destination register index, latched on accepted start
//   elem_valid   producer has an element
//   elem_data    element value (SEW bits)
//   elem_ready   collector takes an element this cycle (COLLECT only)
//   vmask        per-lane write enable, latched on start   (VMASK_EN)
//   old_data     current vd contents, lane-aligned          (VMASK_EN)
//   busy         collection or write in progress
//   write, is_v  one-cycle register-file write strobe and qualifier
//   vd_addr      latched destination index
//   data         assembled vector; lane i at data[i*SEW +: SEW]
// ---------------------------------------------------------------------------

// One lane of the assembly buffer.
module vector_wb_lane #(
   parameter int SEW = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           we,
   input  logic [SEW-1:0] d,
   output logic [SEW-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst || clr) q <= '0;
      else if (we)    q <= d;
   end
endmodule

module vector_wb_collector #(
   parameter int VL  = 8,
   parameter int SEW = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [4:0]        vd_in,
   input  logic              elem_valid,
   input  logic [SEW-1:0]    elem_data,
`ifdef VMASK_EN
   input  logic [VL-1:0]     vmask,
   input  logic [VL*SEW-1:0] old_data,
`endif
   output logic              elem_ready,
   output logic              busy,
   output logic              write,
   output logic              is_v,
   output logic [4:0]        vd_addr,
   output logic [VL*SEW-1:0] data
);
   localparam int IW = (VL > 1) ? $clog2(VL) : 1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2
   } state_t;

   state_t                    state_q, state_d;
   logic   [IW-1:0]           idx_q;
   logic                      start_acc;
   logic                      accept;
   logic                      last_lane;
   logic   [VL-1:0][SEW-1:0]  lane_q;
`ifdef VMASK_EN
   logic   [VL-1:0]           vmask_q;
`endif

   assign last_lane = (idx_q == IW'(VL-1));

   // Next state and outputs. All outputs decode the state register only,
   // so elem_ready never depends on elem_valid and write has no input path.
   always_comb begin
      state_d    = state_q;
      elem_ready = 1'b0;
      busy       = 1'b0;
      write      = 1'b0;
      start_acc  = 1'b0;
      accept     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_d   = S_COLLECT;
            end
         end
         S_COLLECT: begin
            elem_ready = 1'b1;
            busy       = 1'b1;
            if (elem_valid) begin
               accept = 1'b1;
               if (last_lane) state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            write   = 1'b1;
            busy    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign is_v = write;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         vd_addr <= '0;
`ifdef VMASK_EN
         vmask_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         if (start_acc) begin
            idx_q   <= '0;
            vd_addr <= vd_in;
`ifdef VMASK_EN
            vmask_q <= vmask;
`endif
         end else if (accept && !last_lane) begin
            // Holding at VL-1 on the last lane keeps idx from wrapping.
            idx_q <= idx_q + 1'b1;
         end
      end
   end

   // Lane buffer: the lane selected by idx captures on each handshake.
   for (genvar g = 0; g < VL; g++) begin : g_lane
      logic           we;
      logic           clr;
      logic [SEW-1:0] d;

      assign we = accept && (idx_q == IW'(g));
`ifdef VMASK_EN
      // Mask-undisturbed: masked lanes reload the old register contents,
      // so the buffer needs no clear on start.
      assign clr = 1'b0;
      assign d   = vmask_q[g] ? elem_data : old_data[g*SEW +: SEW];
`else
      assign clr = start_acc;
      assign d   = elem_data;
`endif

      vector_wb_lane #(.SEW(SEW)) u_lane (
         .clk (clk),
         .rst (rst),
         .clr (clr),
         .we  (we),
         .d   (d),
         .q   (lane_q[g])
      );
   end

   assign data = lane_q;

endmodule

// File: tb/tb_vector_wb_collector.sv
// ---------------------------------------------------------------------------
// tb_vector_wb_collector
//   Directed bench for vector_wb_collector (VL=8, SEW=32). Inputs change 1
//   time unit after the rising edge; a negedge monitor logs every write with
//   its cycle number relative to the start of the current scenario.
//   Build with VMASK_EN defined to add the masked-lane scenario.
// ---------------------------------------------------------------------------
module tb_vector_wb_collector;
   localparam int VL  = 8;
   localparam int SEW = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [4:0]        vd_in;
   logic              elem_valid;
   logic [SEW-1:0]    elem_data;
   logic              elem_ready;
   logic              busy;
   logic              write;
   logic              is_v;
   logic [4:0]        vd_addr;
   logic [VL*SEW-1:0] data;
`ifdef VMASK_EN
   logic [VL-1:0]     vmask;
   logic [VL*SEW-1:0] old_data;
`endif

   vector_wb_collector #(.VL(VL), .SEW(SEW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .vd_in      (vd_in),
      .elem_valid (elem_valid),
      .elem_data  (elem_data),
`ifdef VMASK_EN
      .vmask      (vmask),
      .old_data   (old_data),
`endif
      .elem_ready (elem_ready),
      .busy       (busy),
      .write      (write),
      .is_v       (is_v),
      .vd_addr    (vd_addr),
      .data       (data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [VL*SEW-1:0] got,
                      input logic [VL*SEW-1:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Write log, cycles relative to t0 (the cycle start was driven in).
   int                t0 = 0;
   int                wr_cyc[$];
   logic [4:0]        wr_addr[$];
   logic [VL*SEW-1:0] wr_data[$];

   always @(negedge clk) begin
      if (write === 1'b1) begin
         wr_cyc.push_back(cyc - t0);
         wr_addr.push_back(vd_addr);
         wr_data.push_back(data);
         chk("is_v_on_write", {255'd0, is_v}, 1);
         chk("busy_on_write", {255'd0, busy}, 1);
         chk("ready_on_write", {255'd0, elem_ready}, 0);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_cyc.delete();
      wr_addr.delete();
      wr_data.delete();
   endtask

   function automatic logic [VL*SEW-1:0] ramp(input logic [SEW-1:0] base);
      logic [VL*SEW-1:0] v;
      v = '0;
      for (int i = 0; i < VL; i++) v[i*SEW +: SEW] = base + SEW'(i);
      return v;
   endfunction

   // One collection of VL elements base, base+1, ... With bubbles, valid is
   // only high on odd cycles. With mid, start is pulsed (vd_in=9) in cycle 3.
   task automatic collect(input string tag, input logic [4:0] vd,
                          input logic [SEW-1:0] base, input bit bubbles,
                          input bit mid, input int ew,
                          input logic [VL*SEW-1:0] expv);
      int lane;
      clear_log();
      t0         = cyc;
      start      = 1'b1;
      vd_in      = vd;
      elem_valid = 1'b0;
      step();
      lane = 0;
      for (int c = 1; c <= 24; c++) begin
         start      = mid && (c == 3);
         vd_in      = (mid && c == 3) ? 5'd9 : vd;
         elem_valid = (lane < VL) && (!bubbles || (c % 2 == 1));
         elem_data  = base + SEW'(lane);
         if (c == ew + 1) chk({tag, "_busy_after"}, {255'd0, busy}, 0);
         if (elem_valid && elem_ready) lane++;
         step();
      end
      start      = 1'b0;
      elem_valid = 1'b0;
      chk({tag, "_handshakes"}, lane, VL);
      chk({tag, "_wr_count"}, wr_cyc.size(), 1);
      if (wr_cyc.size() >= 1) begin
         chk({tag, "_wr_cycle"}, wr_cyc[0], ew);
         chk({tag, "_vd_addr"}, {251'd0, wr_addr[0]}, {251'd0, vd});
         chk({tag, "_data"}, wr_data[0], expv);
      end
      chk({tag, "_data_hold"}, data, expv);
   endtask

   initial begin
      logic [VL*SEW-1:0] mexp;
      int lane;
      rst        = 1'b1;
      start      = 1'b0;
      vd_in      = '0;
      elem_valid = 1'b0;
      elem_data  = '0;
`ifdef VMASK_EN
      vmask      = '1;
      old_data   = '0;
`endif
      step();
      step();
      rst = 1'b0;
      chk("rst_write", {255'd0, write}, 0);
      chk("rst_busy", {255'd0, busy}, 0);
      chk("rst_ready", {255'd0, elem_ready}, 0);
      chk("rst_data", data, 0);
      chk("rst_vd_addr", {251'd0, vd_addr}, 0);
      clear_log();
      repeat (20) step();
      chk("idle_no_write", wr_cyc.size(), 0);

      // Continuous stream, write lands in cycle VL+1.
      collect("stream", 5'd5, 32'h10, 1'b0, 1'b0, 9, ramp(32'h10));

      // Every-other-cycle bubbles plus an ignored mid-collection start.
      collect("bubble", 5'd5, 32'h10, 1'b1, 1'b1, 16, ramp(32'h10));

      // Reset after 4 accepted lanes, then a clean collection to vd 0.
      clear_log();
      t0 = cyc;
      start = 1'b1; vd_in = 5'd7; step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         elem_valid = 1'b1;
         elem_data  = 32'h50 + i;
         step();
      end
      elem_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", {255'd0, busy}, 0);
      chk("midrst_ready", {255'd0, elem_ready}, 0);
      chk("midrst_data", data, 0);
      chk("midrst_vd_addr", {251'd0, vd_addr}, 0);
      repeat (12) step();
      chk("midrst_no_write", wr_cyc.size(), 0);
      collect("after_rst", 5'd0, 32'hA0, 1'b0, 1'b0, 9, ramp(32'hA0));

      // Back-to-back: start in cycle 9 is ignored, cycle 10 is accepted.
      clear_log();
      t0 = cyc;
      start = 1'b1; vd_in = 5'd5; elem_valid = 1'b0;
      step();
      lane = 0;
      for (int c = 1; c <= 24; c++) begin
         start      = (c == 9) || (c == 10);
         vd_in      = (c >= 9) ? 5'd31 : 5'd5;
         elem_valid = (lane < 2*VL);
         elem_data  = (lane < VL) ? 32'h10 + lane : 32'h20 + (lane - VL);
         if (elem_valid && elem_ready) lane++;
         step();
      end
      start = 1'b0;
      elem_valid = 1'b0;
      chk("b2b_wr_count", wr_cyc.size(), 2);
      if (wr_cyc.size() >= 2) begin
         chk("b2b_wr0_cycle", wr_cyc[0], 9);
         chk("b2b_wr0_vd", {251'd0, wr_addr[0]}, 5);
         chk("b2b_wr0_data", wr_data[0], ramp(32'h10));
         chk("b2b_wr1_cycle", wr_cyc[1], 19);
         chk("b2b_wr1_vd", {251'd0, wr_addr[1]}, 31);
         chk("b2b_wr1_data", wr_data[1], ramp(32'h20));
      end

`ifdef VMASK_EN
      // Odd lanes masked off: they keep old_data yet still take a handshake.
      vmask    = 8'b0101_0101;
      old_data = '1;
      mexp     = '0;
      for (int i = 0; i < VL; i++)
         mexp[i*SEW +: SEW] = (i % 2 == 0) ? 32'(i) : 32'hFFFF_FFFF;
      collect("vmask", 5'd2, 32'h0, 1'b0, 1'b0, 9, mexp);
`else
      mexp = '0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // Hard stop so the run always ends, even if the stimulus stalls.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
